// File: rtl/icache_ctrl_wt.sv
// Direct-mapped, write-through, no-write-allocate cache controller between the core and a block-read memory.
// Optional hit/miss statistics counters are enabled by defining CACHE_STATS_EN.
module icache_ctrl_wt #(
    parameter int NUM_LINES = 4,
    parameter int IDX_W     = 2,
    parameter int MEM_LAT   = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [31:0]  addr,
    input  logic [31:0]  w_data,
    input  logic         rd,
    input  logic         wr,
    output logic [31:0]  r_data,
    output logic         stall,
    output logic [31:0]  mem_addr,
    output logic [31:0]  mem_w_data,
    output logic         mem_wr_en,
    output logic         mem_rd_en,
    input  logic [127:0] mem_r_data,
    output logic [1:0]   dbg_state
`ifdef CACHE_STATS_EN
    ,
    output logic [15:0]  hit_cnt,
    output logic [15:0]  miss_cnt
`endif
);

    localparam int TAG_W = 32 - IDX_W - 2;
    localparam int CNT_W = $clog2(MEM_LAT) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LAT - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_MISS = 2'd1,
        WR_MEM  = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [NUM_LINES-1:0]   valid_q;
    logic [TAG_W-1:0]       tag_q  [NUM_LINES];
    logic [31:0]            data_q [NUM_LINES][4];

    logic [IDX_W-1:0]       idx;
    logic [TAG_W-1:0]       tag;
    logic [1:0]             off;
    logic                   hit;
    logic                   fill_en;
    logic                   wr_hit_en;

    assign idx        = addr[IDX_W+1:2];
    assign tag        = addr[31:IDX_W+2];
    assign off        = addr[1:0];
    assign hit        = valid_q[idx] && (tag_q[idx] == tag);
    assign mem_w_data = w_data;
    assign dbg_state  = state_q;

    // Reset aborts an in-flight fill or store update; arrays keep their contents otherwise.
    assign fill_en   = !reset && (state_q == RD_MISS) && (cnt_q == CNT_LAST);
    assign wr_hit_en = !reset && (state_q == WR_MEM) && hit;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            valid_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (fill_en) begin
                valid_q[idx] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (fill_en) begin
            tag_q[idx] <= tag;
            for (int w = 0; w < 4; w++) begin
                data_q[idx][w] <= mem_r_data[32*w +: 32];
            end
        end else if (wr_hit_en) begin
            data_q[idx][off] <= w_data;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (wr) begin
                    state_d = WR_MEM;
                end else if (rd && !hit) begin
                    state_d = RD_MISS;
                    cnt_d   = '0;
                end
            end
            RD_MISS: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d = IDLE;
                end
            end
            WR_MEM:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        stall     = 1'b0;
        r_data    = '0;
        mem_rd_en = 1'b0;
        mem_wr_en = 1'b0;
        mem_addr  = addr;
        if (!reset) begin
            case (state_q)
                IDLE: begin
                    if (wr) begin
                        stall = 1'b1;
                    end else if (rd) begin
                        if (hit) begin
                            r_data = data_q[idx][off];
                        end else begin
                            stall = 1'b1;
                        end
                    end
                end
                RD_MISS: begin
                    stall     = 1'b1;
                    mem_rd_en = 1'b1;
                    mem_addr  = {addr[31:2], 2'b00};
                end
                WR_MEM:  mem_wr_en = 1'b1;
                default: ;
            endcase
        end
    end

`ifdef CACHE_STATS_EN
    logic [15:0] hit_cnt_q, miss_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else if (state_q == IDLE && rd && !wr) begin
            if (hit && hit_cnt_q != 16'hFFFF) begin
                hit_cnt_q <= hit_cnt_q + 16'd1;
            end
            if (!hit && miss_cnt_q != 16'hFFFF) begin
                miss_cnt_q <= miss_cnt_q + 16'd1;
            end
        end
    end

    assign hit_cnt  = hit_cnt_q;
    assign miss_cnt = miss_cnt_q;
`endif

endmodule

// File: tb/tb_icache_ctrl_wt.sv
// Testbench for icache_ctrl_wt: behavioural memory, line-presence model and an expected-load-data queue.
// Statistics outputs are checked when CACHE_STATS_EN is defined.
module tb_icache_ctrl_wt;

    localparam int MEM_LAT = 2;

    logic         clk = 1'b0;
    logic         reset;
    logic [31:0]  addr;
    logic [31:0]  w_data;
    logic         rd;
    logic         wr;
    logic [31:0]  r_data;
    logic         stall;
    logic [31:0]  mem_addr;
    logic [31:0]  mem_w_data;
    logic         mem_wr_en;
    logic         mem_rd_en;
    logic [127:0] mem_r_data;
    logic [1:0]   dbg_state;
`ifdef CACHE_STATS_EN
    logic [15:0]  hit_cnt;
    logic [15:0]  miss_cnt;
`endif

    int checks   = 0;
    int failures = 0;
    int exp_hits   = 0;
    int exp_misses = 0;

    logic [31:0] exp_q[$];
    logic [31:0] mem     [256];
    logic [31:0] ref_mem [256];
    logic        model_valid [4];
    logic [27:0] model_tag   [4];

    always #5 clk = ~clk;

    icache_ctrl_wt #(
        .NUM_LINES(4),
        .IDX_W(2),
        .MEM_LAT(MEM_LAT)
    ) dut (
        .clk(clk),
        .reset(reset),
        .addr(addr),
        .w_data(w_data),
        .rd(rd),
        .wr(wr),
        .r_data(r_data),
        .stall(stall),
        .mem_addr(mem_addr),
        .mem_w_data(mem_w_data),
        .mem_wr_en(mem_wr_en),
        .mem_rd_en(mem_rd_en),
        .mem_r_data(mem_r_data),
        .dbg_state(dbg_state)
`ifdef CACHE_STATS_EN
        ,
        .hit_cnt(hit_cnt),
        .miss_cnt(miss_cnt)
`endif
    );

    // Block-read data memory: combinational block output, word write on the clock edge.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            mem_r_data[32*i +: 32] = mem[{mem_addr[7:2], 2'(i)}];
        end
    end

    always @(posedge clk) begin
        if (mem_wr_en) begin
            mem[mem_addr[7:0]] <= mem_w_data;
        end
    end

    task automatic model_invalidate();
        for (int i = 0; i < 4; i++) begin
            model_valid[i] = 1'b0;
            model_tag[i]   = '0;
        end
        exp_hits   = 0;
        exp_misses = 0;
    endtask

    // Entered and left just after a rising edge.
    task automatic load(input logic [31:0] a, input string name);
        logic        was_hit;
        int          n_stall;
        int          n_rd;
        logic        addr_bad;
        logic        both_bad;
        logic [31:0] exp;
        was_hit  = model_valid[a[3:2]] && (model_tag[a[3:2]] == a[31:4]);
        exp_q.push_back(ref_mem[a[7:0]]);
        rd = 1'b1; wr = 1'b0; addr = a; w_data = $urandom;
        n_stall = 0; n_rd = 0; addr_bad = 1'b0; both_bad = 1'b0;
        @(negedge clk);
        while (stall && n_stall < 50) begin
            n_stall++;
            if (mem_rd_en) begin
                n_rd++;
                if (mem_addr !== {a[31:2], 2'b00}) addr_bad = 1'b1;
                if (mem_wr_en) both_bad = 1'b1;
            end
            @(negedge clk);
        end
        checks++;
        if (n_stall !== (was_hit ? 0 : MEM_LAT + 1)) begin
            failures++;
            $display("FAIL %s_stall_cycles: got %0d expected %0d", name, n_stall, was_hit ? 0 : MEM_LAT + 1);
        end
        checks++;
        if (n_rd !== (was_hit ? 0 : MEM_LAT)) begin
            failures++;
            $display("FAIL %s_rd_en_cycles: got %0d expected %0d", name, n_rd, was_hit ? 0 : MEM_LAT);
        end
        checks++;
        if ({addr_bad, both_bad, mem_rd_en} !== 3'b000) begin
            failures++;
            $display("FAIL %s_mem_rd_bus: got addr_bad/both_en/rd_en_on_hit=%b expected 000", name, {addr_bad, both_bad, mem_rd_en});
        end
        exp = exp_q.pop_front();
        checks++;
        if (r_data !== exp) begin
            failures++;
            $display("FAIL %s_r_data: got %h expected %h", name, r_data, exp);
        end
        @(posedge clk); #1;
        rd = 1'b0;
        model_valid[a[3:2]] = 1'b1;
        model_tag[a[3:2]]   = a[31:4];
        exp_hits++;
        if (!was_hit) exp_misses++;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d, input logic rd_too, input string name);
        rd = rd_too; wr = 1'b1; addr = a; w_data = d;
        @(negedge clk);
        checks++;
        if ({stall, mem_wr_en, mem_rd_en} !== 3'b100) begin
            failures++;
            $display("FAIL %s_req_cycle: got stall/wr_en/rd_en=%b expected 100", name, {stall, mem_wr_en, mem_rd_en});
        end
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if ({mem_wr_en, mem_rd_en, stall, mem_addr, mem_w_data} !== {1'b1, 1'b0, 1'b0, a, d}) begin
            failures++;
            $display("FAIL %s_mem_write: got wr/rd/stall=%b addr=%h data=%h expected 100 addr=%h data=%h",
                     name, {mem_wr_en, mem_rd_en, stall}, mem_addr, mem_w_data, a, d);
        end
        @(posedge clk); #1;
        wr = 1'b0; rd = 1'b0;
        @(negedge clk);
        checks++;
        if (mem_wr_en !== 1'b0) begin
            failures++;
            $display("FAIL %s_single_pulse: got mem_wr_en=%b expected 0", name, mem_wr_en);
        end
        @(posedge clk); #1;
        ref_mem[a[7:0]] = d;
    endtask

    task automatic test_reset();
        reset = 1'b1; rd = 1'b1; wr = 1'b1; addr = 32'd5; w_data = 32'h1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({stall, mem_rd_en, mem_wr_en, r_data} !== 35'd0) begin
            failures++;
            $display("FAIL reset_outputs: got stall/rd/wr=%b r_data=%h expected 000 r_data=0",
                     {stall, mem_rd_en, mem_wr_en}, r_data);
        end
        @(posedge clk); #1;
        reset = 1'b0; rd = 1'b0; wr = 1'b0;
        @(negedge clk);
        checks++;
        if ({dbg_state, stall} !== 3'b000) begin
            failures++;
            $display("FAIL reset_idle: got state=%0d stall=%b expected 0 0", dbg_state, stall);
        end
`ifdef CACHE_STATS_EN
        checks++;
        if ({hit_cnt, miss_cnt} !== 32'd0) begin
            failures++;
            $display("FAIL reset_stats: got hit=%0d miss=%0d expected 0 0", hit_cnt, miss_cnt);
        end
`endif
        @(posedge clk); #1;
        model_invalidate();
    endtask

    task automatic test_reset_abort();
        rd = 1'b1; wr = 1'b0; addr = 32'd8;
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if ({stall, mem_rd_en} !== 2'b11) begin
            failures++;
            $display("FAIL abort_first_miss_cycle: got stall/rd_en=%b expected 11", {stall, mem_rd_en});
        end
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if ({stall, mem_rd_en, mem_wr_en, r_data} !== 35'd0) begin
            failures++;
            $display("FAIL abort_reset_cycle: got stall/rd/wr=%b r_data=%h expected 000 0",
                     {stall, mem_rd_en, mem_wr_en}, r_data);
        end
        @(posedge clk); #1;
        reset = 1'b0; rd = 1'b0;
        @(negedge clk);
        checks++;
        if ({dbg_state, stall, mem_rd_en} !== 4'b0000) begin
            failures++;
            $display("FAIL abort_idle: got state=%0d stall=%b rd_en=%b expected 0 0 0", dbg_state, stall, mem_rd_en);
        end
        @(posedge clk); #1;
        model_invalidate();
        load(32'd5, "abort_rd5");
        load(32'd8, "abort_rd8");
    endtask

    task automatic test_random();
        logic [31:0] a;
        for (int i = 0; i < 24; i++) begin
            a = 32'($urandom_range(0, 63));
            if ($urandom_range(0, 2) == 0) store(a, $urandom, 1'b0, "rand_st");
            else load(a, "rand_ld");
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i]     = '0;
            ref_mem[i] = '0;
        end
        reset = 1'b1; rd = 1'b0; wr = 1'b0; addr = '0; w_data = '0;
        model_invalidate();

        test_reset();
        load(32'd5, "cold_rd5");
        store(32'd5, 32'hDEADBEEF, 1'b0, "st5_hit");
        load(32'd5, "rd5_after_st");
`ifdef CACHE_STATS_EN
        checks++;
        if ({hit_cnt, miss_cnt} !== {16'(exp_hits), 16'(exp_misses)}) begin
            failures++;
            $display("FAIL stats_early: got hit=%0d miss=%0d expected %0d %0d", hit_cnt, miss_cnt, exp_hits, exp_misses);
        end
`endif
        load(32'd21, "conflict_rd21");
        load(32'd5, "refetch_rd5");
        store(32'd40, 32'h12345678, 1'b0, "st40_miss");
        load(32'd40, "rd40_after_st");
        test_reset_abort();
        store(32'd2, 32'd7, 1'b1, "st2_rdwr");
        load(32'd2, "rd2_after_st");
        test_random();

        checks++;
        if (exp_q.size() !== 0) begin
            failures++;
            $display("FAIL exp_queue_drained: got %0d entries expected 0", exp_q.size());
        end
`ifdef CACHE_STATS_EN
        checks++;
        if ({hit_cnt, miss_cnt} !== {16'(exp_hits), 16'(exp_misses)}) begin
            failures++;
            $display("FAIL stats_final: got hit=%0d miss=%0d expected %0d %0d", hit_cnt, miss_cnt, exp_hits, exp_misses);
        end
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        failures++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
